// File: rtl/mask_centroid_pkg.sv
// Shared widths, divider length and FSM encoding for the mask centroid block.
package mask_centroid_pkg;

  localparam int SUM_W      = 32;
  localparam int CNT_W      = 20;
  localparam int DIV_CYCLES = 32;
  localparam int X_W        = 11;
  localparam int Y_W        = 10;

  typedef enum logic [1:0] {
    IDLE,
    DIV_X,
    DIV_Y,
    DONE
  } state_t;

endpackage

// File: rtl/mask_centroid_divider_serial.sv
// Restoring radix-2 unsigned divider: one quotient bit per cycle, first bit on the start edge.
module divider_serial
  import mask_centroid_pkg::*;
#(
  parameter int Q_W = X_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int STEP_W = $clog2(DIV_CYCLES);

  logic [CNT_W-1:0]  rem_q, dvs_q;
  logic [SUM_W-1:0]  dvd_q;
  logic [STEP_W-1:0] step_q;
  logic              running_q;

  logic [CNT_W-1:0]  rem_src, dvs_src, rem_next;
  logic [SUM_W-1:0]  dvd_src, dvd_next;
  logic [CNT_W:0]    trial;
  logic              take;

  // The start cycle consumes the ports directly so the division fits in exactly DIV_CYCLES edges.
  always_comb begin
    // NOTE: every variable is assigned on every path through this block, so no latch is inferred.
    rem_src  = start ? '0 : rem_q;
    dvd_src  = start ? dividend : dvd_q;
    dvs_src  = start ? divisor : dvs_q;
    trial    = {rem_src, dvd_src[SUM_W-1]};
    take     = (trial >= {1'b0, dvs_src});
    rem_next = take ? CNT_W'(trial - {1'b0, dvs_src}) : trial[CNT_W-1:0];
    dvd_next = {dvd_src[SUM_W-2:0], take};
  end

  // NOTE: state updates use non-blocking assignments; every register, datapath included, clears on reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rem_q     <= '0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      step_q    <= '0;
      running_q <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q     <= rem_next;
        dvd_q     <= dvd_next;
        dvs_q     <= divisor;
        step_q    <= STEP_W'(1);
        running_q <= 1'b1;
      end else if (running_q) begin
        rem_q  <= rem_next;
        dvd_q  <= dvd_next;
        step_q <= step_q + STEP_W'(1);
        if (step_q == STEP_W'(DIV_CYCLES - 1)) begin
          running_q <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

  // Quotient bits shift in at the LSB end of the dividend register.
  assign quotient = dvd_q[Q_W-1:0];

endmodule

// File: rtl/mask_centroid.sv
// Accumulates mask pixel coordinates per frame and reports the floor centroid via a shared serial divider.
module mask_centroid
  import mask_centroid_pkg::*;
#(
  parameter int H_WIDTH    = 1280,
  parameter int V_HEIGHT   = 720,
  parameter int MIN_PIXELS = 16
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           valid_in,
  input  logic           mask_in,
  input  logic [X_W-1:0] hcount_in,
  input  logic [Y_W-1:0] vcount_in,
  input  logic           frame_end_in,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           found_out,
  output logic           valid_out,
  output logic           busy_out,
  output logic           dropped_out
);

  state_t state;

  logic [SUM_W-1:0] sum_x, sum_y, hold_sum_y;
  logic [CNT_W-1:0] count, hold_count;
  logic [X_W-1:0]   x_res;

  logic             pix_hit;
  logic [SUM_W-1:0] frame_sum_x, frame_sum_y;
  logic [CNT_W-1:0] frame_count;

  logic             div_start, div_done;
  logic [SUM_W-1:0] div_dividend;
  logic [CNT_W-1:0] div_divisor;
  logic [X_W-1:0]   div_quotient;

  // frame_* include this cycle's pixel, so a pixel coincident with frame_end lands in the closing frame.
  always_comb begin
    pix_hit = valid_in && mask_in
              && (hcount_in < X_W'(H_WIDTH)) && (vcount_in < Y_W'(V_HEIGHT));
    frame_sum_x = sum_x + (pix_hit ? SUM_W'(hcount_in) : '0);
    frame_sum_y = sum_y + (pix_hit ? SUM_W'(vcount_in) : '0);
    frame_count = count + CNT_W'(pix_hit);

    // X divides straight from the closing sums; the divider's shift register is its snapshot.
    div_start    = 1'b0;
    div_dividend = frame_sum_x;
    div_divisor  = frame_count;
    if (state == IDLE) begin
      div_start = frame_end_in && (frame_count != '0);
    end else if (state == DIV_X) begin
      div_start    = div_done;
      div_dividend = hold_sum_y;
      div_divisor  = hold_count;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sum_x      <= '0;
      sum_y      <= '0;
      count      <= '0;
      hold_sum_y <= '0;
      hold_count <= '0;
    end else if (frame_end_in) begin
      sum_x <= '0;
      sum_y <= '0;
      count <= '0;
      if (state == IDLE) begin
        hold_sum_y <= frame_sum_y;
        hold_count <= frame_count;
      end
    end else if (pix_hit) begin
      sum_x <= frame_sum_x;
      sum_y <= frame_sum_y;
      count <= frame_count;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      x_res       <= '0;
      x_out       <= '0;
      y_out       <= '0;
      found_out   <= 1'b0;
      valid_out   <= 1'b0;
      dropped_out <= 1'b0;
    end else begin
      valid_out   <= 1'b0;
      dropped_out <= frame_end_in && (state != IDLE);
      case (state)
        IDLE: begin
          if (frame_end_in) begin
            if (frame_count != '0) begin
              state <= DIV_X;
            end else begin
              x_out     <= '0;
              y_out     <= '0;
              found_out <= 1'b0;
              valid_out <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DIV_X: begin
          if (div_done) begin
            x_res <= div_quotient;
            state <= DIV_Y;
          end
        end
        DIV_Y: begin
          if (div_done) begin
            x_out     <= x_res;
            y_out     <= div_quotient[Y_W-1:0];
            found_out <= (hold_count >= CNT_W'(MIN_PIXELS));
            valid_out <= 1'b1;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_out = (state != IDLE);

  divider_serial #(
    .Q_W(X_W)
  ) u_div (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quotient)
  );

endmodule

// File: tb/tb_mask_centroid.sv
// Directed bench for mask_centroid: hand-computed centroids, latencies, drop and reset behaviour.
module tb_mask_centroid;

  logic        clk_in       = 1'b0;
  logic        rst_in       = 1'b0;
  logic        valid_in     = 1'b0;
  logic        mask_in      = 1'b0;
  logic [10:0] hcount_in    = '0;
  logic [9:0]  vcount_in    = '0;
  logic        frame_end_in = 1'b0;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        found_out, valid_out, busy_out, dropped_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int fe_cyc = 0;

  mask_centroid #(
    .H_WIDTH(1280),
    .V_HEIGHT(720),
    .MIN_PIXELS(16)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .valid_in     (valid_in),
    .mask_in      (mask_in),
    .hcount_in    (hcount_in),
    .vcount_in    (vcount_in),
    .frame_end_in (frame_end_in),
    .x_out        (x_out),
    .y_out        (y_out),
    .found_out    (found_out),
    .valid_out    (valid_out),
    .busy_out     (busy_out),
    .dropped_out  (dropped_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic pix(input int h, input int v);
    valid_in  = 1'b1;
    mask_in   = 1'b1;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    tick();
    valid_in  = 1'b0;
    mask_in   = 1'b0;
  endtask

  task automatic end_frame();
    frame_end_in = 1'b1;
    fe_cyc       = cyc;
    tick();
    frame_end_in = 1'b0;
  endtask

  // Latency is measured from the frame_end cycle (cycle 0) to the cycle valid_out is seen high.
  task automatic wait_valid(output int lat);
    int n;
    n = 0;
    while (valid_out !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    lat = cyc - fe_cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int a_fe;
    int seen;

    // Reset state
    repeat (3) tick();
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_found", found_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_dropped", dropped_out, 0);
    rst_in = 1'b1;
    tick();

    // Single pixel at (100,50)
    pix(100, 50);
    end_frame();
    check("single_busy", busy_out, 1);
    wait_valid(lat);
    check("single_lat", lat, 65);
    check("single_x", x_out, 100);
    check("single_y", y_out, 50);
    check("single_found", found_out, 0);
    tick();
    check("single_valid_pulse", valid_out, 0);
    check("single_x_hold", x_out, 100);
    check("single_idle", busy_out, 0);

    // Empty frame
    end_frame();
    wait_valid(lat);
    check("empty_lat", lat, 1);
    check("empty_x", x_out, 0);
    check("empty_y", y_out, 0);
    check("empty_found", found_out, 0);
    tick();

    // 4x4 block, one invalid pixel to ignore, last pixel coincident with frame_end
    for (int r = 300; r < 304; r++) begin
      for (int c = 200; c < 204; c++) begin
        if (r == 303 && c == 203) begin
          valid_in     = 1'b1;
          mask_in      = 1'b1;
          hcount_in    = 11'(c);
          vcount_in    = 10'(r);
          frame_end_in = 1'b1;
          fe_cyc       = cyc;
          tick();
          valid_in     = 1'b0;
          mask_in      = 1'b0;
          frame_end_in = 1'b0;
        end else begin
          pix(c, r);
        end
      end
      if (r == 300) begin
        valid_in  = 1'b0;
        mask_in   = 1'b1;
        hcount_in = 11'd1000;
        vcount_in = 10'd700;
        tick();
        mask_in   = 1'b0;
      end
    end
    wait_valid(lat);
    check("block_lat", lat, 65);
    check("block_x", x_out, 201);
    check("block_y", y_out, 301);
    check("block_found", found_out, 1);
    tick();

    // Drop: second frame_end 10 cycles after the first while dividing
    pix(300, 400);
    end_frame();
    a_fe = fe_cyc;
    repeat (8) pix(5, 5);
    tick();
    frame_end_in = 1'b1;
    tick();
    frame_end_in = 1'b0;
    check("drop_pulse", dropped_out, 1);
    check("drop_busy", busy_out, 1);
    check("drop_x_hold", x_out, 201);
    pix(20, 30);
    check("drop_pulse_end", dropped_out, 0);
    pix(40, 70);
    fe_cyc = a_fe;
    wait_valid(lat);
    check("drop_first_lat", lat, 65);
    check("drop_first_x", x_out, 300);
    check("drop_first_y", y_out, 400);
    tick();
    end_frame();
    wait_valid(lat);
    check("third_lat", lat, 65);
    check("third_x", x_out, 30);
    check("third_y", y_out, 50);
    check("third_found", found_out, 0);
    tick();

    // Wide sums: alternating extreme corners give the full-frame centroid
    for (int i = 0; i < 16384; i++) begin
      pix(0, 0);
      pix(1279, 719);
    end
    end_frame();
    wait_valid(lat);
    check("wide_lat", lat, 65);
    check("wide_x", x_out, 639);
    check("wide_y", y_out, 359);
    check("wide_found", found_out, 1);
    tick();

    // Reset at cycle 20 of DIV_X
    pix(50, 60);
    end_frame();
    repeat (19) tick();
    check("mid_busy", busy_out, 1);
    rst_in = 1'b0;
    #1;
    check("mid_rst_x", x_out, 0);
    check("mid_rst_y", y_out, 0);
    check("mid_rst_found", found_out, 0);
    check("mid_rst_busy", busy_out, 0);
    check("mid_rst_valid", valid_out, 0);
    pix(9, 9);
    rst_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (valid_out === 1'b1) seen++;
    end
    check("post_rst_no_valid", seen, 0);
    pix(7, 9);
    end_frame();
    wait_valid(lat);
    check("post_rst_lat", lat, 65);
    check("post_rst_x", x_out, 7);
    check("post_rst_y", y_out, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
